cram_diag_loader: RTL

- Sequencer that writes one 80-bit microword into CRAM through the EBUS diagnostic-function path.
- Issues, in order: load diag address high (052), load diag address low (051), then write functions 057 (00_19), 056 (20_39), 055 (40_59) and 054 (60_79).
- Sits between the DTE-side microcode-load logic and the CTL diagnostic-function decode; it owns the function code, data and strobe timing.

---
 rtl/cram_diag_loader_pkg.sv | 38 +++
 rtl/cram_diag_step_mux.sv | 51 +++++
 rtl/cram_diag_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cram_diag_loader_pkg.sv
// Purpose: shared types and constants for the CRAM diagnostic-function loader.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: loader state enum, EBUS diag function codes, CRAM geometry and a
// helper that folds a microword into its 20-bit chunk checksum.
package cram_diag_loader_pkg;

    localparam int CRAM_WORD_BITS = 80;
    localparam int CRAM_ADR_BITS  = 11;
    localparam int DIAG_DATA_BITS = 36;
    localparam int CHUNK_BITS     = 20;

    // Last index of the six-function write sequence.
    localparam logic [2:0] LAST_STEP = 3'd5;

    localparam logic [6:0] DIAG_LDADR_HI = 7'o052;
    localparam logic [6:0] DIAG_LDADR_LO = 7'o051;
    localparam logic [6:0] DIAG_WR_00_19 = 7'o057;
    localparam logic [6:0] DIAG_WR_20_39 = 7'o056;
    localparam logic [6:0] DIAG_WR_40_59 = 7'o055;
    localparam logic [6:0] DIAG_WR_60_79 = 7'o054;

    // ABORTED is the one-cycle cancel state that sits between an abort and IDLE.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        ABORTED
    } tCramLdState;

    // XOR of the four 20-bit chunks of a microword; bit 0 is the MSB (DEC numbering).
    function automatic logic [CHUNK_BITS-1:0] word_chunk_xor(input logic [0:CRAM_WORD_BITS-1] w);
        return w[0:19] ^ w[20:39] ^ w[40:59] ^ w[60:79];
    endfunction

endpackage

// File: rtl/cram_diag_step_mux.sv
// Purpose: maps the sequence step onto the diag function code and EBUS data.
// Latency: combinational.
// Backpressure: none.
// Ports: step (0..5), adr [0:10], word [0:79] in; func (7-bit octal code), data [0:35] out.
// All vectors use DEC numbering: bit 0 is the most significant bit.
module cram_diag_step_mux
    import cram_diag_loader_pkg::*;
(
    input  logic [2:0]                step,
    input  logic [0:CRAM_ADR_BITS-1]  adr,
    input  logic [0:CRAM_WORD_BITS-1] word,
    output logic [6:0]                func,
    output logic [0:DIAG_DATA_BITS-1] data
);

    always_comb begin
        func = '0;
        data = '0;
        case (step)
            3'd0: begin
                func      = DIAG_LDADR_HI;
                data[1:5] = adr[0:4];
            end
            3'd1: begin
                func      = DIAG_LDADR_LO;
                data[0:5] = adr[5:10];
            end
            3'd2: begin
                func       = DIAG_WR_00_19;
                data[0:19] = word[0:19];
            end
            3'd3: begin
                func       = DIAG_WR_20_39;
                data[0:19] = word[20:39];
            end
            3'd4: begin
                func       = DIAG_WR_40_59;
                data[0:19] = word[40:59];
            end
            3'd5: begin
                func       = DIAG_WR_60_79;
                data[0:19] = word[60:79];
            end
            default: begin
                func = '0;
                data = '0;
            end
        endcase
    end

endmodule

// File: rtl/cram_diag_loader.sv
// Purpose: writes one 80-bit microword into CRAM via six EBUS diag functions (052,051,057,056,055,054).
// Latency: done pulses in cycle 6*(SETUP+STROBE+HOLD)+1 after the accept edge.
// Backpressure: reqReady only in IDLE; a request is held off for the whole load.
// Ports: clk, RESET (sync, active-high); reqValid/reqReady/reqAdr/reqWord request side;
// abort; diagFunc/diagStrobe/diagData to CTL; busy, done, aborted status.
// Optional: CRAM_DIAG_LOADER_STATS_EN adds wordCount (completed loads) and checksum (chunk XOR).
module cram_diag_loader
    import cram_diag_loader_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic                      reqValid,
    output logic                      reqReady,
    input  logic [0:CRAM_ADR_BITS-1]  reqAdr,
    input  logic [0:CRAM_WORD_BITS-1] reqWord,
    input  logic                      abort,
    output logic [6:0]                diagFunc,
    output logic                      diagStrobe,
    output logic [0:DIAG_DATA_BITS-1] diagData,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted
`ifdef CRAM_DIAG_LOADER_STATS_EN
    ,
    output logic [15:0]               wordCount,
    output logic [CHUNK_BITS-1:0]     checksum
`endif
);

    tCramLdState               state, state_nxt;
    logic [2:0]                step, step_nxt;
    logic [15:0]               cnt, cnt_nxt;
    logic                      latch;
    logic [0:CRAM_ADR_BITS-1]  adr_q;
    logic [0:CRAM_WORD_BITS-1] word_q;
    logic [6:0]                mux_func;
    logic [0:DIAG_DATA_BITS-1] mux_data;

    cram_diag_step_mux u_step_mux (
        .step (step),
        .adr  (adr_q),
        .word (word_q),
        .func (mux_func),
        .data (mux_data)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            state  <= IDLE;
            step   <= '0;
            cnt    <= '0;
            adr_q  <= '0;
            word_q <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                adr_q  <= reqAdr;
                word_q <= reqWord;
            end
        end
    end

    // cnt counts cycles spent in the current phase; every phase ends at its length-1.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    state_nxt = SETUP;
                    step_nxt  = '0;
                    cnt_nxt   = '0;
                    latch     = 1'b1;
                end
            end
            SETUP: begin
                if (abort) begin
                    state_nxt = ABORTED;
                end else if (cnt == 16'(SETUP_CYCLES - 1)) begin
                    state_nxt = STROBE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            STROBE: begin
                if (abort) begin
                    state_nxt = ABORTED;
                end else if (cnt == 16'(STROBE_CYCLES - 1)) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            HOLD: begin
                // Abort beats the step/sequence completion decided in the same cycle.
                if (abort) begin
                    state_nxt = ABORTED;
                end else if (cnt == 16'(HOLD_CYCLES - 1)) begin
                    cnt_nxt = '0;
                    if (step == LAST_STEP) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SETUP;
                        step_nxt  = step + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            ABORTED: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from registered state, so they change only on clk edges.
    assign reqReady   = (state == IDLE);
    assign busy       = (state == SETUP) || (state == STROBE) || (state == HOLD);
    assign diagStrobe = (state == STROBE);
    assign done       = (state == DONE);
    assign aborted    = (state == ABORTED);
    assign diagFunc   = busy ? mux_func : '0;
    assign diagData   = busy ? mux_data : '0;

`ifdef CRAM_DIAG_LOADER_STATS_EN
    always_ff @(posedge clk) begin
        if (RESET) begin
            wordCount <= '0;
            checksum  <= '0;
        end else if (state == DONE) begin
            wordCount <= wordCount + 16'd1;
            checksum  <= checksum ^ word_chunk_xor(word_q);
        end
    end
`endif

endmodule
